// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2
  } booth_op_e;

  // Step counter must hold values up to WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth step: conditional add/subtract of M into A, then
// arithmetic shift right of {A,Q,Q_-1}.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] a_in,
  input  logic [WIDTH:0]   q_in,
  input  logic             qm1_in,
  input  logic [WIDTH:0]   m_in,
  output logic [WIDTH+1:0] a_out,
  output logic [WIDTH:0]   q_out,
  output logic             qm1_out
);

  booth_op_e        op;
  logic [WIDTH+1:0] m_ext;
  logic [WIDTH+1:0] sum;

  assign m_ext = {m_in[WIDTH], m_in};

  always_comb begin
    case ({q_in[0], qm1_in})
      2'b01:   op = ADD;
      2'b10:   op = SUB;
      default: op = NOP;
    endcase
  end

  always_comb begin
    case (op)
      ADD:     sum = a_in + m_ext;
      SUB:     sum = a_in - m_ext;
      default: sum = a_in;
    endcase
  end

  assign a_out   = {sum[WIDTH+1], sum[WIDTH+1:1]};
  assign q_out   = {sum[0], q_in[WIDTH:1]};
  assign qm1_out = q_in[0];

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier with start/busy/done handshake and
// per-operation signed/unsigned mode; one Booth step per clock.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH+1:0]   a_q, a_d, a_step;
  logic [WIDTH:0]     q_q, q_d, q_step;
  logic [WIDTH:0]     m_q, m_d;
  logic               qm1_q, qm1_d, qm1_step;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a_in   (a_q),
    .q_in   (q_q),
    .qm1_in (qm1_q),
    .m_in   (m_q),
    .a_out  (a_step),
    .q_out  (q_step),
    .qm1_out(qm1_step)
  );

  // Operands are widened by one bit so unsigned values run through the signed Booth recoding.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    qm1_d     = qm1_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = '0;
          q_d     = signed_mode ? {multiplier[WIDTH-1], multiplier} : {1'b0, multiplier};
          m_d     = signed_mode ? {multiplicand[WIDTH-1], multiplicand} : {1'b0, multiplicand};
          qm1_d   = 1'b0;
          count_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_step;
        q_d     = q_step;
        qm1_d   = qm1_step;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d   = DONE;
          product_d = {a_step[WIDTH-2:0], q_step};
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      qm1_q     <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      qm1_q     <= qm1_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
